// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage between ex_mem and mem_wb.
// Runs loads and stores over a req/ack data bus and stalls the pipeline while
// an access is outstanding. Load data is lane-aligned and sign- or zero-extended.
// Non-memory ops pass the ALU result straight through in the same cycle.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ex_wd/ex_wreg/ex_wdata   destination and ALU result from ex_mem
//   ex_memop                 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW, 9-15 none
//   ex_mem_addr              byte address of the access
//   ex_store_data            store source (rs2)
//   bus_req/we/addr/be/wdata memory request, held until ack or abort
//   bus_ack/bus_rdata        completion, with read data valid in the same cycle
//   stall_req                holds ex_mem and the earlier stages
//   mem_wd/mem_wreg/mem_wdata  result to mem_wb
//   misalign                 1-cycle pulse: misaligned access dropped
//   bus_err                  1-cycle pulse: ack timeout expired
//
// state | meaning
// IDLE  | no access outstanding; pass-through, or launch a request
// WAIT  | request on the bus, waiting for ack or timeout
// RESP  | deliver the load data or store result to mem_wb for one cycle
module mem_access #(
    parameter int ACK_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [3:0]  ex_memop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_store_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall_req,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        misalign,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    state_t state, state_nxt;

    logic [CW-1:0] cnt;
    logic [31:0]   req_addr;
    logic [3:0]    req_be;
    logic [31:0]   req_wdata;
    logic          req_we;
    logic [3:0]    req_op;
    logic [31:0]   ld_data;
    logic          aborted;

    // Decode of the incoming op
    logic        op_load, op_store, op_byte, op_half, op_word, op_mem, op_misal;
    logic [3:0]  ex_be;
    logic [31:0] ex_bwdata;

    always_comb begin
        op_load  = (ex_memop >= 4'd1) && (ex_memop <= 4'd5);
        op_store = (ex_memop >= 4'd6) && (ex_memop <= 4'd8);
        op_byte  = (ex_memop == 4'd1) || (ex_memop == 4'd4) || (ex_memop == 4'd6);
        op_half  = (ex_memop == 4'd2) || (ex_memop == 4'd5) || (ex_memop == 4'd7);
        op_word  = (ex_memop == 4'd3) || (ex_memop == 4'd8);
        op_mem   = op_load || op_store;
        op_misal = (op_half && ex_mem_addr[0]) || (op_word && (ex_mem_addr[1:0] != 2'b00));

        ex_be     = 4'b1111;
        ex_bwdata = ex_store_data;
        if (op_byte) begin
            ex_be     = 4'b0001 << ex_mem_addr[1:0];
            ex_bwdata = {4{ex_store_data[7:0]}};
        end else if (op_half) begin
            ex_be     = 4'b0011 << ex_mem_addr[1:0];
            ex_bwdata = {2{ex_store_data[15:0]}};
        end
    end

    // Load extraction uses the captured request, since ex_* may be held but
    // the captured copy is what the bus was actually given.
    logic [31:0] rd_shift;
    logic [31:0] ld_ext;
    logic        req_is_load;

    always_comb begin
        rd_shift    = bus_rdata >> {req_addr[1:0], 3'b000};
        req_is_load = (req_op >= 4'd1) && (req_op <= 4'd5);
        case (req_op)
            4'd1:    ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            4'd2:    ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            4'd4:    ld_ext = {24'd0, rd_shift[7:0]};
            4'd5:    ld_ext = {16'd0, rd_shift[15:0]};
            default: ld_ext = bus_rdata;
        endcase
    end

    logic timeout_hit;
    assign timeout_hit = (ACK_TIMEOUT != 0) && (state == WAIT) && !bus_ack && (cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ld_data   <= '0;
            aborted   <= 1'b0;
            req_addr  <= '0;
            req_be    <= '0;
            req_wdata <= '0;
            req_we    <= 1'b0;
            req_op    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (op_mem && !op_misal) begin
                        req_addr  <= ex_mem_addr;
                        req_be    <= ex_be;
                        req_wdata <= ex_bwdata;
                        req_we    <= op_store;
                        req_op    <= ex_memop;
                        aborted   <= 1'b0;
                        cnt       <= '0;
                    end
                end
                WAIT: begin
                    if (bus_ack) begin
                        ld_data <= ld_ext;
                    end else if (timeout_hit) begin
                        aborted <= 1'b1;
                    end
                    if (cnt != {CW{1'b1}}) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_be    = '0;
        bus_wdata = '0;
        stall_req = 1'b0;
        mem_wd    = ex_wd;
        mem_wreg  = 1'b0;
        mem_wdata = ex_wdata;
        misalign  = 1'b0;
        bus_err   = 1'b0;

        case (state)
            IDLE: begin
                if (!op_mem) begin
                    mem_wreg = ex_wreg;
                end else if (op_misal) begin
                    misalign = 1'b1;
                end else begin
                    bus_req   = 1'b1;
                    bus_we    = op_store;
                    bus_addr  = {ex_mem_addr[31:2], 2'b00};
                    bus_be    = ex_be;
                    bus_wdata = ex_bwdata;
                    stall_req = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                bus_req   = 1'b1;
                bus_we    = req_we;
                bus_addr  = {req_addr[31:2], 2'b00};
                bus_be    = req_be;
                bus_wdata = req_wdata;
                stall_req = 1'b1;
                if (bus_ack) begin
                    state_nxt = RESP;
                end else if (timeout_hit) begin
                    bus_err   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                mem_wreg  = ex_wreg && !aborted;
                mem_wdata = req_is_load ? ld_data : ex_wdata;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Everything reads as zero while reset is held, including mem_wd (the NOP register).
        if (rst) begin
            bus_req   = 1'b0;
            bus_we    = 1'b0;
            bus_addr  = '0;
            bus_be    = '0;
            bus_wdata = '0;
            stall_req = 1'b0;
            mem_wd    = '0;
            mem_wreg  = 1'b0;
            mem_wdata = '0;
            misalign  = 1'b0;
            bus_err   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    localparam int TO = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_memop;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_store_data;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        stall_req;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        misalign, bus_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_memop(ex_memop),
        .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .stall_req(stall_req), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .misalign(misalign), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: access size in bytes, 0 when not a memory op.
    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd4, 4'd6: return 1;
            4'd2, 4'd5, 4'd7: return 2;
            4'd3, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic bit op_is_store(input logic [3:0] op);
        return (op >= 4'd6) && (op <= 4'd8);
    endfunction

    function automatic logic [3:0] exp_be(input int sz, input logic [31:0] a);
        int lane;
        lane = a % 4;
        if (sz == 4) return 4'hF;
        return 4'((sz == 1 ? 1 : 3) << lane);
    endfunction

    function automatic logic [31:0] exp_bwdata(input int sz, input logic [31:0] d);
        if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
        longint v;
        v = (rd >> (8 * (a % 4)));
        case (op)
            4'd1: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            4'd2: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            4'd4: v = v % 256;
            4'd5: v = v % 65536;
            default: v = rd;
        endcase
        return v[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one instruction through the stage. d = WAIT cycle (1-based) on which ack arrives.
    task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] wd, input logic w, input logic [31:0] wdat,
                         input int d, input logic [31:0] rd);
        int  sz;
        bit  mis, ab;
        ex_memop = op; ex_mem_addr = addr; ex_store_data = sd;
        ex_wd = wd; ex_wreg = w; ex_wdata = wdat;
        bus_ack = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        sz  = op_size(op);
        mis = (sz == 2 && addr % 2 != 0) || (sz == 4 && addr % 4 != 0);
        @(negedge clk);
        if (sz == 0) begin
            chk("pass_wd", 32'(mem_wd), 32'(wd));
            chk("pass_wreg", 32'(mem_wreg), 32'(w));
            chk("pass_wdata", mem_wdata, wdat);
            chk("pass_stall", 32'(stall_req), 0);
            chk("pass_req", 32'(bus_req), 0);
            step();
            return;
        end
        if (mis) begin
            chk("mis_pulse", 32'(misalign), 1);
            chk("mis_req", 32'(bus_req), 0);
            chk("mis_stall", 32'(stall_req), 0);
            chk("mis_wreg", 32'(mem_wreg), 0);
            step();
            return;
        end
        chk("idle_req", 32'(bus_req), 1);
        chk("idle_stall", 32'(stall_req), 1);
        chk("idle_wreg", 32'(mem_wreg), 0);
        chk("idle_we", 32'(bus_we), 32'(op_is_store(op)));
        chk("idle_addr", bus_addr, addr & 32'hFFFF_FFFC);
        chk("idle_be", 32'(bus_be), 32'(exp_be(sz, addr)));
        if (op_is_store(op)) chk("idle_wdata", bus_wdata, exp_bwdata(sz, sd));
        step();
        ab = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            bus_ack = (k == d);
            bus_rdata = (k == d) ? rd : $urandom;
            @(negedge clk);
            chk("wait_req", 32'(bus_req), 1);
            chk("wait_stall", 32'(stall_req), 1);
            chk("wait_wreg", 32'(mem_wreg), 0);
            chk("wait_addr", bus_addr, addr & 32'hFFFF_FFFC);
            chk("wait_be", 32'(bus_be), 32'(exp_be(sz, addr)));
            if (k == d) begin
                chk("wait_err", 32'(bus_err), 0);
                break;
            end
            if (k == TO) begin
                chk("timeout_err", 32'(bus_err), 1);
                ab = 1'b1;
                break;
            end
            chk("wait_err", 32'(bus_err), 0);
            step();
        end
        step();
        bus_ack = 1'b0;
        @(negedge clk);
        chk("resp_stall", 32'(stall_req), 0);
        chk("resp_req", 32'(bus_req), 0);
        chk("resp_err", 32'(bus_err), 0);
        chk("resp_wd", 32'(mem_wd), 32'(wd));
        chk("resp_wreg", 32'(mem_wreg), ab ? 0 : 32'(w));
        if (!op_is_store(op) && !ab) chk("resp_load", mem_wdata, exp_load(op, addr, rd));
        if (op_is_store(op)) chk("resp_store", mem_wdata, wdat);
        step();
    endtask

    initial begin
        rst = 1'b1;
        ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'hDEAD_BEEF; ex_memop = 4'd3;
        ex_mem_addr = 32'h100; ex_store_data = 32'h1; bus_ack = 1'b1; bus_rdata = 32'h5;
        step();
        @(negedge clk);
        chk("rst_req", 32'(bus_req), 0);
        chk("rst_stall", 32'(stall_req), 0);
        chk("rst_wd", 32'(mem_wd), 0);
        chk("rst_wreg", 32'(mem_wreg), 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_be", 32'(bus_be), 0);
        step();
        rst = 1'b0;

        do_op(4'd0, 32'h0,   32'h0,         5'd5, 1'b1, 32'h1234,      1, 32'h0);
        do_op(4'd1, 32'h103, 32'h0,         5'd3, 1'b1, 32'h0,         1, 32'h80FF_FF7F);
        do_op(4'd5, 32'h102, 32'h0,         5'd4, 1'b1, 32'h0,         4, 32'hBEEF_0000);
        do_op(4'd7, 32'h202, 32'hAAAA_1234, 5'd0, 1'b1, 32'h0000_0204, 1, 32'h0);
        do_op(4'd3, 32'h101, 32'h0,         5'd6, 1'b1, 32'h0,         1, 32'h0);
        do_op(4'd3, 32'h300, 32'h0,         5'd8, 1'b1, 32'h0,         7, 32'h0);
        do_op(4'd8, 32'h304, 32'h1122_3344, 5'd9, 1'b1, 32'h77,        TO, 32'h0);

        for (int i = 0; i < 300; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (op_size(op) == 2) ? {a[1], 1'b0} : 2'b00;
            do_op(op, a, $urandom, 5'($urandom), 1'($urandom), $urandom,
                  $urandom_range(1, TO + 2), $urandom);
        end

        // Reset in the middle of WAIT, then a late ack that must be ignored.
        ex_memop = 4'd3; ex_mem_addr = 32'h400; ex_wd = 5'd2; ex_wreg = 1'b1; ex_wdata = 32'h99;
        bus_ack = 1'b0;
        step();
        @(negedge clk);
        chk("rw_wait_req", 32'(bus_req), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rw_rst_req", 32'(bus_req), 0);
        step();
        rst = 1'b0;
        ex_memop = 4'd0; ex_wd = 5'd11; ex_wreg = 1'b1; ex_wdata = 32'hCAFE;
        bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
        @(negedge clk);
        chk("late_ack_req", 32'(bus_req), 0);
        chk("late_ack_stall", 32'(stall_req), 0);
        chk("late_ack_wdata", mem_wdata, 32'hCAFE);
        step();
        do_op(4'd2, 32'h502, 32'h0, 5'd12, 1'b1, 32'h0, 2, 32'h8001_7FFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
